// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by the transmit serializer and the receive path:
// the frame state encoding and the default frame geometry.
//   UART_DATA_BITS  : payload bits per frame (8N1 by default)
//   UART_OVERSAMPLE : sample_tick pulses per bit period
//   uart_state_e    : IDLE / START / DATA / STOP frame states
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/tx_bit_timer.sv
// -----------------------------------------------------------------------------
// tx_bit_timer
// Counts sample_tick pulses and flags the tick that closes a bit period.
// Ports:
//   clk       : clock
//   rst_n     : asynchronous active-low reset
//   i_clear   : hold the counter at zero (overrides ticks)
//   i_tick    : one-clk-wide oversample enable
//   o_bit_end : high on the tick that completes OVERSAMPLE ticks
// -----------------------------------------------------------------------------
module tx_bit_timer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_tick,
  output logic o_bit_end
);

  localparam int               CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(OVERSAMPLE - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last    = (r_cnt == LAST);
  // A clear in the same cycle as a tick wins, so the tick is not counted.
  assign o_bit_end = i_tick & w_last & ~i_clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_tick) begin
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
// Serializes one payload word per request into an 8N1 frame: start bit (0),
// DATA_BITS data bits LSB first, one stop bit (1). Bit timing comes from
// sample_tick, OVERSAMPLE ticks per bit.
// Ports:
//   clk         : clock, all state updates on rising edge
//   rst_n       : asynchronous active-low reset
//   sample_tick : one-clk-wide oversample enable
//   tx_data     : payload, sampled only on acceptance
//   tx_valid    : send request
//   tx_ready    : high only while idle
//   tx_out      : registered serial line, idle high
//   tx_done     : one-clk pulse as the frame completes
// -----------------------------------------------------------------------------
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 tx_done
);

  localparam int               IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  uart_state_e          r_state;
  uart_state_e          w_state_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic [IDX_W-1:0]     r_bit_idx;
  logic [IDX_W-1:0]     w_bit_idx_nxt;
  logic                 r_tx_out;
  logic                 w_tx_out_nxt;
  logic                 r_tx_done;
  logic                 w_tx_done_nxt;
  logic                 w_timer_clr;
  logic                 w_bit_end;

  // Holding the timer clear throughout IDLE also clears it on the acceptance
  // edge, so the first tick counted is the one in the cycle after acceptance.
  assign w_timer_clr = (r_state == ST_IDLE);

  tx_bit_timer #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_bit_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_timer_clr),
    .i_tick    (sample_tick),
    .o_bit_end (w_bit_end)
  );

  assign tx_ready = (r_state == ST_IDLE);
  assign tx_out   = r_tx_out;
  assign tx_done  = r_tx_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_tx_out  <= 1'b1;
      r_tx_done <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_tx_out  <= w_tx_out_nxt;
      r_tx_done <= w_tx_done_nxt;
    end
  end

  // The line level for the next bit is decided here and registered, so tx_out
  // changes on the same edge as the state.
  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_idx_nxt = r_bit_idx;
    w_tx_out_nxt  = r_tx_out;
    w_tx_done_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_tx_out_nxt = 1'b1;
        if (tx_valid) begin
          w_state_nxt   = ST_START;
          w_shift_nxt   = tx_data;
          w_bit_idx_nxt = '0;
          w_tx_out_nxt  = 1'b0;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_state_nxt  = ST_DATA;
          w_tx_out_nxt = r_shift[0];
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          w_shift_nxt = r_shift >> 1;
          if (r_bit_idx == LAST_IDX) begin
            w_state_nxt   = ST_STOP;
            w_bit_idx_nxt = '0;
            w_tx_out_nxt  = 1'b1;
          end else begin
            w_bit_idx_nxt = r_bit_idx + IDX_W'(1);
            w_tx_out_nxt  = w_shift_nxt[0];
          end
        end
      end
      ST_STOP: begin
        if (w_bit_end) begin
          w_state_nxt   = ST_IDLE;
          w_tx_done_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_tx_out_nxt = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_serializer
// Scoreboard bench: stimulus pushes each requested payload into a queue; a
// monitor on the falling clock edge tracks the frame timeline from the number
// of sample ticks seen since acceptance and compares the line against the
// expected 8N1 bit sequence, the done pulse and the ready flag.
// -----------------------------------------------------------------------------
module tb_uart_tx_serializer;

  localparam int DB          = 8;
  localparam int OS          = 16;
  localparam int FRAME_TICKS = (DB + 2) * OS;

  logic          clk;
  logic          rst_n;
  logic          sample_tick;
  logic [DB-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          tx_out;
  logic          tx_done;

  uart_tx_serializer #(
    .DATA_BITS  (DB),
    .OVERSAMPLE (OS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_tick (sample_tick),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_out      (tx_out),
    .tx_done     (tx_done)
  );

  int            total     = 0;
  int            bad       = 0;
  logic [DB-1:0] exp_q[$];
  int            n_sent    = 0;
  int            n_aborted = 0;
  int            n_done    = 0;
  int            tick_div  = 1;  // 0: ticks off, k>0: every k-th clk, <0: random
  int            idle_bad  = 0;

  // Monitor model state
  logic          m_busy  = 1'b0;
  logic          m_pend  = 1'b0;
  int            m_ticks = 0;
  int            m_bad   = 0;
  int            m_first = 0;
  logic          m_got   = 1'b0;
  logic          m_want  = 1'b0;
  logic [DB-1:0] m_byte  = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, want);
    end
  endtask

  // Expected line level for frame bit number b (0 = start, DB+1 = stop).
  function automatic logic exp_level(input logic [DB-1:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= DB) return d[b-1];
    return 1'b1;
  endfunction

  task automatic tick_edge();
    @(posedge clk);
    #1;
  endtask

  // Tick generator
  initial begin : tick_gen
    int cnt;
    cnt = 0;
    sample_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cnt++;
      if (tick_div > 0)      sample_tick = ((cnt % tick_div) == 0);
      else if (tick_div < 0) sample_tick = 1'($urandom_range(0, 1));
      else                   sample_tick = 1'b0;
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_pend = 1'b0;
      chk("reset_state", 32'({tx_out, tx_ready, tx_done}), 32'b110);
    end else begin
      if (m_pend) begin
        m_pend = 1'b0;
        chk("accept_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) m_byte = exp_q.pop_front();
        m_busy  = 1'b1;
        m_ticks = 0;
        m_bad   = 0;
      end
      if (m_busy && m_ticks == FRAME_TICKS) begin
        chk("done_cycle", 32'({tx_out, tx_ready, tx_done}), 32'b111);
        if (m_bad != 0)
          $display("  frame byte=%h first deviation at tick %0d, line=%b", m_byte, m_first, m_got);
        chk("frame_shape", 32'(m_bad), 32'd0);
        m_busy = 1'b0;
      end else if (m_busy) begin
        m_want = exp_level(m_byte, m_ticks / OS);
        if (tx_out !== m_want || tx_ready !== 1'b0 || tx_done !== 1'b0) begin
          if (m_bad == 0) begin
            m_first = m_ticks;
            m_got   = tx_out;
          end
          m_bad++;
        end
        if (sample_tick === 1'b1) m_ticks++;
      end else begin
        if (tx_out !== 1'b1 || tx_ready !== 1'b1 || tx_done !== 1'b0) idle_bad++;
      end
      if (tx_done === 1'b1) n_done++;
      if (!m_busy && tx_valid === 1'b1) m_pend = 1'b1;
    end
  end

  // Request a frame and return one cycle after the acceptance edge.
  task automatic send(input logic [DB-1:0] d, input bit hold);
    bit ok;
    tx_data  = d;
    tx_valid = 1'b1;
    exp_q.push_back(d);
    n_sent++;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (tx_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept_seen", 32'(ok), 32'd1);
    tick_edge();
    if (!hold) tx_valid = 1'b0;
    tx_data = DB'($urandom);
  endtask

  // Wait for tx_done; cycles counts falling edges passed before it appeared.
  task automatic wait_done(input int limit, output int cycles);
    cycles = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (tx_done === 1'b1) begin
        cycles = i;
        break;
      end
    end
    chk("done_seen", 32'(cycles >= 0), 32'd1);
    tick_edge();
  endtask

  initial begin : stim
    int lat;
    int cnt;
    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) tick_edge();

    // 0x55, tick always high: 160 clks to done
    tick_div = 1;
    tick_edge();
    send(8'h55, 1'b0);
    wait_done(400, lat);
    chk("latency_55", 32'(lat), 32'd160);

    // 0xA5, tick every 4th clk
    tick_div = 4;
    tick_edge();
    send(8'hA5, 1'b0);
    wait_done(1000, lat);

    // Back-to-back 0x00 then 0xFF with valid held
    tick_div = 1;
    tick_edge();
    send(8'h00, 1'b1);
    send(8'hFF, 1'b0);
    wait_done(400, lat);
    chk("latency_ff", 32'(lat), 32'd160);

    // 0xC3 with tx_data/tx_valid disturbed mid-frame
    send(8'hC3, 1'b0);
    repeat (40) tick_edge();
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    repeat (30) tick_edge();
    tx_valid = 1'b0;
    wait_done(400, lat);
    chk("latency_c3", 32'(lat), 32'd90);

    // Ticks held low after acceptance: start bit persists
    tick_div = 0;
    tick_edge();
    send(8'h6B, 1'b0);
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_out !== 1'b0 || tx_ready !== 1'b0) cnt++;
    end
    chk("start_hold_no_ticks", 32'(cnt), 32'd0);
    tick_edge();
    tick_div = 1;
    wait_done(400, lat);

    // Reset during data bit 3, then a frame on the first edge after release
    send(8'h96, 1'b0);
    repeat (72) tick_edge();
    rst_n = 1'b0;
    #1;
    chk("reset_async", 32'({tx_out, tx_ready, tx_done}), 32'b110);
    n_aborted++;
    tx_data  = 8'h3A;
    tx_valid = 1'b1;
    exp_q.push_back(8'h3A);
    n_sent++;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", 32'(tx_ready), 32'd1);
    tick_edge();
    chk("accept_first_edge", 32'(tx_out), 32'd0);
    tx_valid = 1'b0;
    wait_done(400, lat);
    chk("latency_after_reset", 32'(lat), 32'd160);

    // Randomized frames, tick rates and back-to-back holds
    for (int i = 0; i < 16; i++) begin
      bit hold_v;
      int r;
      r        = $urandom_range(0, 5);
      tick_div = (r == 5) ? -1 : r + 1;
      hold_v   = (i < 15) && ($urandom_range(0, 1) == 1);
      send(DB'($urandom), hold_v);
      if (!hold_v) begin
        wait_done(2000, lat);
        repeat ($urandom_range(0, 3)) tick_edge();
      end
    end

    tick_div = 1;
    repeat (20) tick_edge();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("frames_done", 32'(n_done), 32'(n_sent - n_aborted));
    chk("idle_line", 32'(idle_bad), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 Parameter DATA_BITS, default 8: payload bits per frame.
REQ-002 Parameter OVERSAMPLE, default 16: sample_tick pulses per bit period.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 Port clk, input, 1: sole clock, all state updates on its rising edge.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Port sample_tick, input, 1: one-clk-wide 16x baud enable, the same tick the receive-side bit sample counter uses.
REQ-007 Port tx_data, input, DATA_BITS: byte to send, sampled only on acceptance.
REQ-008 Port tx_valid, input, 1: request to send tx_data.
REQ-009 Port tx_ready, output, 1: high only in IDLE.
REQ-010 Port tx_out, output, 1: serial line, idle high.
REQ-011 Port tx_done, output, 1: one-clk pulse at frame end.

Function
REQ-012 The frame SHALL be 8N1: start bit 0, DATA_BITS data bits LSB first, one stop bit 1.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-014 Acceptance SHALL be tx_valid && tx_ready at a clk edge: latch tx_data into a shift register, clear the tick and bit counters, and enter START.
REQ-015 tx_out SHALL equal 0 from the first clk after acceptance.
REQ-016 The 4-bit tick counter SHALL increment only on sample_tick; on a tick with count == OVERSAMPLE-1 it SHALL wrap to 0 and end the current bit.
REQ-017 Each bit SHALL last exactly OVERSAMPLE ticks; ticks are counted only from the cycle after acceptance.
REQ-018 On bit end: START goes to DATA; DATA shifts right and increments the bit index, and at index DATA_BITS-1 goes to STOP; STOP goes to IDLE.
REQ-019 tx_out SHALL be registered, with no combinational path from inputs.
REQ-020 tx_done SHALL pulse high for exactly one clk on the STOP-to-IDLE edge, and tx_ready SHALL be high in that same cycle.
REQ-021 tx_valid and tx_data SHALL be ignored while not in IDLE; the latched byte SHALL be unaffected.
REQ-022 With sample_tick held high, acceptance to tx_done SHALL take 160 clks.
REQ-023 With tx_valid held high, back-to-back frames SHALL leave at least 1 clk of tx_out=1 between the stop bit and the next start bit.

Reset
REQ-024 While rst_n=0 the block SHALL hold state IDLE, tx_out=1, tx_ready=1, tx_done=0, and all counters and the shift register at 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no tx_done.
REQ-026 After release, the first acceptance SHALL be possible on the first clk edge with rst_n=1.

Structure
REQ-027 Package uart_pkg SHALL hold the state enum type and the DATA_BITS and OVERSAMPLE defaults, shared with the receive path.
REQ-028 Sub-module tx_bit_timer SHALL hold the tick counter, with a clear input and a bit_end output.

Verification
REQ-029 Send 0x55 with tick always high -> tx_out runs 0,1,0,1,0,1,0,1,0,1, 16 clks each; tx_done 160 clks after acceptance.
REQ-030 Send 0xA5 with a tick every 4th clk -> each bit is 64 clks; data bits on the line are 1,0,1,0,0,1,0,1.
REQ-031 Hold tx_valid high with 0x00, then 0xFF -> two frames, 1 idle-high clk between them, second payload all 1s.
REQ-032 Change tx_data to 0x3C mid-frame while sending 0xC3 -> line still carries 0xC3; tx_ready stays 0 until tx_done.
REQ-033 Assert rst_n=0 during data bit 3 -> tx_out=1 and tx_ready=1 immediately; no tx_done; a new frame sends correctly after release.
REQ-034 Hold sample_tick low for 100 clks after acceptance -> tx_out stays 0 and the state stays START.
